sram_arbiter: RTL and testbench



---
 rtl/sram_arbiter_if.sv | 49 ++++
 rtl/sram_arbiter.sv | 133 +++++++++++++
 tb/tb_sram_arbiter.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_arbiter_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : sram_arbiter_if
// Purpose  : Requester, SRAM and status signals around sram_arbiter.
// Revision : 1.0
// ============================================================================
interface sram_arbiter_if;
    logic        p0_req;
    logic        p0_we;
    logic [15:0] p0_addr;
    logic [15:0] p0_wdata;
    logic        p0_done;
    logic [15:0] p0_rdata;

    logic        p1_req;
    logic        p1_we;
    logic [15:0] p1_addr;
    logic [15:0] p1_wdata;
    logic        p1_done;
    logic [15:0] p1_rdata;

    logic [15:0] SRAM_address;
    logic [15:0] SRAM_wdata;
    logic        SRAM_write_en;
    logic [15:0] SRAM_read_data;

    logic [1:0]  grant;
    logic        busy;

    // Environment side: requesters plus the SRAM device.
    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        output p1_req, p1_we, p1_addr, p1_wdata,
        output SRAM_read_data,
        input  p0_done, p0_rdata, p1_done, p1_rdata,
        input  SRAM_address, SRAM_wdata, SRAM_write_en, grant, busy
    );

    // Arbiter side.
    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        input  SRAM_read_data,
        output p0_done, p0_rdata, p1_done, p1_rdata,
        output SRAM_address, SRAM_wdata, SRAM_write_en, grant, busy
    );
endinterface
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : sram_arbiter
// Purpose  : Round-robin two-port sequencer for a single fixed-latency SRAM.
// Revision : 1.0
// ============================================================================
module sram_arbiter #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [15:0] IDLE_ADDR   = 16'hFFFF
) (
    input  logic          clk,
    input  logic          reset,
    sram_arbiter_if.slave bus
);
    localparam logic [3:0] c_cnt_last = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        last_grant_q;
    logic [1:0]  grant_q;
    logic        busy_q;
    logic        p0_done_q;
    logic        p1_done_q;
    logic [15:0] p0_rdata_q;
    logic [15:0] p1_rdata_q;
    logic [15:0] sram_addr_q;
    logic [15:0] sram_wdata_q;
    logic        sram_we_q;

    logic        any_req_d;
    logic        sel_p1_d;
    logic        we_d;
    logic        null_d;
    logic [15:0] addr_d;
    logic [15:0] wdata_d;

    // Tie goes to whichever port was not served last.
    always_comb begin
        any_req_d = bus.p0_req | bus.p1_req;
        sel_p1_d  = bus.p1_req & (~bus.p0_req | ~last_grant_q);
        we_d      = sel_p1_d ? bus.p1_we    : bus.p0_we;
        addr_d    = sel_p1_d ? bus.p1_addr  : bus.p0_addr;
        wdata_d   = sel_p1_d ? bus.p1_wdata : bus.p0_wdata;
        null_d    = (addr_d == IDLE_ADDR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            last_grant_q <= 1'b1;
            grant_q      <= 2'b00;
            busy_q       <= 1'b0;
            p0_done_q    <= 1'b0;
            p1_done_q    <= 1'b0;
            p0_rdata_q   <= 16'hFFFF;
            p1_rdata_q   <= 16'hFFFF;
            sram_addr_q  <= IDLE_ADDR;
            sram_wdata_q <= 16'h0000;
            sram_we_q    <= 1'b0;
        end else begin
            p0_done_q <= 1'b0;
            p1_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (any_req_d) begin
                        grant_q      <= sel_p1_d ? 2'b10 : 2'b01;
                        last_grant_q <= sel_p1_d;
                        busy_q       <= 1'b1;
                        cnt_q        <= 4'd0;
                        sram_wdata_q <= wdata_d;
                        if (null_d) begin
                            // Null access completes immediately without touching the SRAM.
                            state_q <= S_DONE;
                            if (sel_p1_d) begin
                                p1_done_q <= 1'b1;
                                if (!we_d) p1_rdata_q <= 16'hFFFF;
                            end else begin
                                p0_done_q <= 1'b1;
                                if (!we_d) p0_rdata_q <= 16'hFFFF;
                            end
                        end else begin
                            state_q     <= S_BUSY;
                            sram_addr_q <= addr_d;
                            sram_we_q   <= we_d;
                        end
                    end
                end
                S_BUSY: begin
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == c_cnt_last) begin
                        state_q     <= S_DONE;
                        sram_addr_q <= IDLE_ADDR;
                        sram_we_q   <= 1'b0;
                        if (grant_q[1]) begin
                            p1_done_q <= 1'b1;
                            if (!sram_we_q) p1_rdata_q <= bus.SRAM_read_data;
                        end else begin
                            p0_done_q <= 1'b1;
                            if (!sram_we_q) p0_rdata_q <= bus.SRAM_read_data;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    grant_q <= 2'b00;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.p0_done       = p0_done_q;
    assign bus.p1_done       = p1_done_q;
    assign bus.p0_rdata      = p0_rdata_q;
    assign bus.p1_rdata      = p1_rdata_q;
    assign bus.SRAM_address  = sram_addr_q;
    assign bus.SRAM_wdata    = sram_wdata_q;
    assign bus.SRAM_write_en = sram_we_q;
    assign bus.grant         = grant_q;
    assign bus.busy          = busy_q;
endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_sram_arbiter
// Purpose  : Self-checking bench for sram_arbiter against a transaction-level model.
// Revision : 1.0
// ============================================================================
module tb_sram_arbiter;
    localparam int W = 2;

    logic clk;
    logic reset;
    int   n_total;
    int   n_pass;

    logic [15:0] exp_rdata [2];

    sram_arbiter_if bus ();

    sram_arbiter #(.WAIT_CYCLES(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_port(input int p, input logic req, input logic we,
                              input logic [15:0] addr, input logic [15:0] wdata);
        if (p == 0) begin
            bus.p0_req = req; bus.p0_we = we; bus.p0_addr = addr; bus.p0_wdata = wdata;
        end else begin
            bus.p1_req = req; bus.p1_we = we; bus.p1_addr = addr; bus.p1_wdata = wdata;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive_port(0, 1'b0, 1'b0, 16'h0, 16'h0);
        drive_port(1, 1'b0, 1'b0, 16'h0, 16'h0);
        bus.SRAM_read_data = 16'h0;
        step();
        step();
        reset = 1'b0;
        exp_rdata[0] = 16'hFFFF;
        exp_rdata[1] = 16'hFFFF;
    endtask

    // One isolated request; the requester scrambles its inputs after the grant,
    // and the SRAM only presents valid read data in the last BUSY cycle.
    task automatic run_single(input string nm, input int p, input logic we,
                              input logic [15:0] addr, input logic [15:0] wdata,
                              input logic [15:0] sval);
        logic        nul;
        logic        in_busy;
        int          last;
        logic [1:0]  oh;
        logic [53:0] obs;
        logic [53:0] exp;
        nul  = (addr == 16'hFFFF);
        last = nul ? 1 : W + 1;
        oh   = (p == 1) ? 2'b10 : 2'b01;
        drive_port(p, 1'b1, we, addr, wdata);
        drive_port(1 - p, 1'b0, 1'b0, 16'h0, 16'h0);
        bus.SRAM_read_data = 16'($urandom);
        for (int c = 1; c <= last + 1; c++) begin
            step();
            in_busy = !nul && (c <= W);
            if (c == last && !we) exp_rdata[p] = nul ? 16'hFFFF : sval;
            obs = {bus.grant, bus.busy, bus.p1_done, bus.p0_done, bus.SRAM_write_en,
                   bus.SRAM_address, bus.p0_rdata, bus.p1_rdata};
            exp = {(c <= last) ? oh : 2'b00, (c <= last), (c == last) ? oh : 2'b00,
                   in_busy & we, in_busy ? addr : 16'hFFFF, exp_rdata[0], exp_rdata[1]};
            n_total++;
            if (obs !== exp)
                $display("FAIL %s cyc%0d {grant,busy,done,we,addr,rd0,rd1}: got %h want %h",
                         nm, c, obs, exp);
            else n_pass++;
            if (in_busy && we) begin
                n_total++;
                if (bus.SRAM_wdata !== wdata)
                    $display("FAIL %s wdata cyc%0d: got %h want %h", nm, c, bus.SRAM_wdata, wdata);
                else n_pass++;
            end
            bus.SRAM_read_data = (in_busy && c == W) ? sval : 16'($urandom);
            if (c == last)
                drive_port(p, 1'b0, we, addr, wdata);
            else if (c < last)
                drive_port(p, 1'b1, 1'($urandom), 16'($urandom), 16'($urandom));
        end
    endtask

    task automatic test_reset();
        logic [69:0] obs;
        logic [69:0] exp;
        reset = 1'b1;
        drive_port(0, 1'b0, 1'b0, 16'h0, 16'h0);
        drive_port(1, 1'b0, 1'b0, 16'h0, 16'h0);
        bus.SRAM_read_data = 16'h0;
        step();
        step();
        exp = {2'b00, 1'b0, 2'b00, 1'b0, 16'hFFFF, 16'h0000, 16'hFFFF, 16'hFFFF};
        obs = {bus.grant, bus.busy, bus.p1_done, bus.p0_done, bus.SRAM_write_en,
               bus.SRAM_address, bus.SRAM_wdata, bus.p0_rdata, bus.p1_rdata};
        n_total++;
        if (obs !== exp) $display("FAIL reset_vals: got %h want %h", obs, exp);
        else n_pass++;
        reset = 1'b0;
        exp_rdata[0] = 16'hFFFF;
        exp_rdata[1] = 16'hFFFF;
        step();
        obs = {bus.grant, bus.busy, bus.p1_done, bus.p0_done, bus.SRAM_write_en,
               bus.SRAM_address, bus.SRAM_wdata, bus.p0_rdata, bus.p1_rdata};
        n_total++;
        if (obs !== exp) $display("FAIL idle_after_reset: got %h want %h", obs, exp);
        else n_pass++;
    endtask

    task automatic test_read();
        run_single("p1_read", 1, 1'b0, 16'h1234, 16'h0, 16'hBEEF);
    endtask

    task automatic test_write();
        run_single("p0_write", 0, 1'b1, 16'h0010, 16'h00AA, 16'h5A5A);
    endtask

    task automatic test_null();
        run_single("null_write_p0", 0, 1'b1, 16'hFFFF, 16'h1111, 16'h2222);
        run_single("null_read_p1", 1, 1'b0, 16'hFFFF, 16'h0, 16'h3333);
    endtask

    task automatic test_addr_change();
        run_single("p0_latch", 0, 1'b0, 16'h0042, 16'h0, 16'hC0DE);
    endtask

    // Both ports request continuously; the model expects strict alternation
    // starting with port 0 and one idle cycle between transactions.
    task automatic test_back_to_back();
        logic        we_a [2];
        logic [15:0] addr_a [2];
        logic [15:0] wd_a [2];
        logic [15:0] sval;
        logic [1:0]  oh;
        logic [53:0] obs;
        logic [53:0] exp;
        int          win;
        do_reset();
        for (int p = 0; p < 2; p++) begin
            we_a[p] = 1'($urandom); addr_a[p] = 16'($urandom_range(0, 15)); wd_a[p] = 16'($urandom);
            drive_port(p, 1'b1, we_a[p], addr_a[p], wd_a[p]);
        end
        for (int k = 0; k < 6; k++) begin
            win  = k % 2;
            oh   = (win == 1) ? 2'b10 : 2'b01;
            sval = 16'($urandom);
            bus.SRAM_read_data = 16'($urandom);
            for (int c = 1; c <= W + 1; c++) begin
                step();
                if (c == W + 1 && !we_a[win]) exp_rdata[win] = sval;
                obs = {bus.grant, bus.busy, bus.p1_done, bus.p0_done, bus.SRAM_write_en,
                       bus.SRAM_address, bus.p0_rdata, bus.p1_rdata};
                exp = {oh, 1'b1, (c == W + 1) ? oh : 2'b00, (c <= W) & we_a[win],
                       (c <= W) ? addr_a[win] : 16'hFFFF, exp_rdata[0], exp_rdata[1]};
                n_total++;
                if (obs !== exp)
                    $display("FAIL b2b txn%0d cyc%0d: got %h want %h", k, c, obs, exp);
                else n_pass++;
                bus.SRAM_read_data = (c == W) ? sval : 16'($urandom);
                if (c == W + 1) begin
                    we_a[win] = 1'($urandom); addr_a[win] = 16'($urandom_range(0, 15));
                    wd_a[win] = 16'($urandom);
                    drive_port(win, 1'b1, we_a[win], addr_a[win], wd_a[win]);
                end
            end
            step();
            n_total++;
            if ({bus.grant, bus.busy} !== 3'b000)
                $display("FAIL b2b idle txn%0d {grant,busy}: got %b want 000", k, {bus.grant, bus.busy});
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        logic [53:0] obs;
        logic [53:0] exp;
        do_reset();
        run_single("pre_read", 0, 1'b0, 16'h0005, 16'h0, 16'h1357);
        drive_port(0, 1'b1, 1'b1, 16'h0003, 16'($urandom));
        step();
        n_total++;
        if ({bus.SRAM_write_en, bus.grant} !== 3'b101)
            $display("FAIL mid_write_start {we,grant}: got %b want 101", {bus.SRAM_write_en, bus.grant});
        else n_pass++;
        reset = 1'b1;
        step();
        exp_rdata[0] = 16'hFFFF;
        exp_rdata[1] = 16'hFFFF;
        obs = {bus.grant, bus.busy, bus.p1_done, bus.p0_done, bus.SRAM_write_en,
               bus.SRAM_address, bus.p0_rdata, bus.p1_rdata};
        exp = {2'b00, 1'b0, 2'b00, 1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        n_total++;
        if (obs !== exp) $display("FAIL mid_reset: got %h want %h", obs, exp);
        else n_pass++;
        reset = 1'b0;
        drive_port(0, 1'b0, 1'b0, 16'h0, 16'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            n_total++;
            if ({bus.grant, bus.busy, bus.p1_done, bus.p0_done, bus.SRAM_write_en} !== 6'b0)
                $display("FAIL post_reset_quiet cyc%0d: got %b want 000000", i,
                         {bus.grant, bus.busy, bus.p1_done, bus.p0_done, bus.SRAM_write_en});
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [15:0] addr;
        for (int i = 0; i < 16; i++) begin
            addr = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom_range(0, 15));
            run_single("random", int'($urandom_range(0, 1)), 1'($urandom), addr,
                       16'($urandom), 16'($urandom));
        end
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        exp_rdata[0] = 16'hFFFF;
        exp_rdata[1] = 16'hFFFF;
        reset = 1'b1;
        test_reset();
        test_read();
        test_write();
        test_null();
        test_addr_change();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
